// File: rtl/multi_mode_shift_unit.sv
// multi_mode_shift_unit: multi-cycle shift/rotate engine, one bit position per step.
// Ports: clk, rst_n, start, enable, mode[2:0], amt[AMT_W-1:0], data_in[WIDTH-1:0]
//        -> data_out[WIDTH-1:0], carry, busy, done.
module multi_mode_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [2:0]       mode_q, mode_nx;
    logic [WIDTH-1:0] data_nx, step_d;
    logic             carry_nx, step_c;

    // Single-bit step on the working register, selected by the latched mode.
    always_comb begin
        step_d = data_out;
        step_c = 1'b0;
        unique case (mode_q)
            3'd0: begin
                step_d = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
                step_c = data_out[0];
            end
            3'd1: begin
                step_d = {1'b0, data_out[WIDTH-1:1]};
                step_c = data_out[0];
            end
            3'd2: begin
                step_d = {data_out[WIDTH-2:0], 1'b0};
                step_c = data_out[WIDTH-1];
            end
            3'd3: begin
                step_d = {data_out[0], data_out[WIDTH-1:1]};
                step_c = data_out[0];
            end
            3'd4: begin
                step_d = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
                step_c = data_out[WIDTH-1];
            end
            default: begin
                step_d = data_out;
                step_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode_q;
        data_nx  = data_out;
        carry_nx = carry;
        unique case (state)
            IDLE: begin
                if (start) begin
                    data_nx  = data_in;
                    mode_nx  = mode;
                    cnt_nx   = amt;
                    carry_nx = 1'b0;
                    state_nx = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    data_nx  = step_d;
                    carry_nx = step_c;
                    cnt_nx   = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mode_q   <= '0;
            data_out <= '0;
            carry    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            mode_q   <= mode_nx;
            data_out <= data_nx;
            carry    <= carry_nx;
        end
    end

    // Both flags decode the state register only, so no input reaches them
    // combinationally.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_multi_mode_shift_unit.sv
// tb_multi_mode_shift_unit: scoreboard bench for multi_mode_shift_unit.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_multi_mode_shift_unit;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          enable;
    logic [2:0]    mode;
    logic [4:0]    amt;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          carry;
    logic          busy;
    logic          done;

    multi_mode_shift_unit #(.WIDTH(W), .AMT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .enable   (enable),
        .mode     (mode),
        .amt      (amt),
        .data_in  (data_in),
        .data_out (data_out),
        .carry    (carry),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           c0;
        int           cdone;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   brun = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] ref_op(input logic [W-1:0] d, input int k, input int m);
        logic [W-1:0] r;
        logic         c;
        int           s;
        r = d;
        c = 1'b0;
        if (k == 0) return {1'b0, d};
        case (m)
            0: begin
                s = (k > W - 1) ? W - 1 : k;
                r = $signed(d) >>> s;
                c = (k <= W) ? d[k-1] : d[W-1];
            end
            1: begin
                r = (k >= W) ? '0 : d >> k;
                c = (k <= W) ? d[k-1] : 1'b0;
            end
            2: begin
                r = (k >= W) ? '0 : d << k;
                c = (k <= W) ? d[W-k] : 1'b0;
            end
            3: begin
                s = k % W;
                r = (d >> s) | (d << (W - s));
                c = r[W-1];
            end
            4: begin
                s = k % W;
                r = (d << s) | (d >> (W - s));
                c = r[0];
            end
            default: begin
                r = d;
                c = 1'b0;
            end
        endcase
        return {c, r};
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            brun = 0;
        end else begin
            if (busy) brun++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", data_out, e.d);
                    check("carry", carry, e.c);
                    check("done_cycle", cyc, e.cdone);
                    check("busy_len", brun, e.cdone - e.c0 + 1);
                end
            end
            if (!busy) brun = 0;
        end
    end

    task automatic push_exp(input logic [W-1:0] d, input int a, input int m,
                            input int c0, input int cdone);
        exp_t       e;
        logic [W:0] r;
        r       = ref_op(d, a, m);
        e.d     = r[W-1:0];
        e.c     = r[W];
        e.c0    = c0;
        e.cdone = cdone;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    task automatic op(input logic [W-1:0] d, input int a, input int m,
                      input int pl, input bit junk);
        int c0;
        int p;
        wait_idle();
        data_in = d;
        amt     = 5'(a);
        mode    = 3'(m);
        start   = 1'b1;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        c0      = cyc;
        start   = 1'b0;
        data_in = W'($urandom);
        amt     = 5'($urandom);
        mode    = 3'($urandom);
        p       = (a > 1) ? pl : 0;
        push_exp(d, a, m, c0, c0 + a + p);
        if (p > 0) begin
            @(posedge clk);
            #1;
            enable = 1'b0;
            if (junk) start = 1'b1;
            repeat (p) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            enable = 1'b1;
        end
    endtask

    initial begin
        int c0;
        int c1;
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        enable  = 1'b1;
        mode    = '0;
        amt     = '0;
        data_in = '0;
        #12;
        check("rst_data", data_out, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(16'hF000, 4, 0, 0, 0);
        op(16'h8001, 1, 1, 0, 0);
        op(16'h8001, 4, 4, 0, 0);
        op(16'hA5A5, 0, 3, 0, 0);
        op(16'hFFFF, 20, 1, 0, 0);
        op(16'h0001, 3, 2, 2, 1);
        op(16'h8421, 31, 0, 0, 0);
        op(16'h1234, 16, 3, 0, 0);
        op(16'h1234, 17, 4, 0, 0);
        op(16'h5A5A, 6, 6, 1, 0);

        op(16'hBEEF, 10, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_carry", carry, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(16'h00F0, 2, 2, 0, 0);

        wait_idle();
        data_in = 16'hC001;
        amt     = 5'd3;
        mode    = 3'd3;
        start   = 1'b1;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        push_exp(16'hC001, 3, 3, c0, c0 + 3);
        data_in = 16'h0F0F;
        amt     = 5'd5;
        mode    = 3'd0;
        c1      = c0 + 3 + 2;
        push_exp(16'h0F0F, 5, 0, c1, c1 + 5);
        n = 0;
        while (cyc < c1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op(W'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
               1'($urandom_range(0, 1)));
        end

        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
